// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate-generation stage between fetch and decode.
// Decodes the 16-bit instruction format, absorbs EXT prefix beats into a
// payload accumulator, and emits instruction, format class and a DW-bit
// sign-extended immediate one cycle after each non-EXT handshake.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop pending prefixes and the output beat
//   in_valid/in_ready    input handshake (in_ready is combinational)
//   in_instr             fetched instruction
//   out_valid/out_ready  output handshake
//   out_instr, out_imm   registered instruction and immediate
//   out_fmt              0=R 1=I 2=S 3=B 4=J
//   out_ext              immediate was widened by at least one prefix
//   err_orphan           one-cycle pulse when a prefix is discarded
module imm_gen_pipe #(
  parameter int unsigned DW      = 16,
  parameter int unsigned MAX_PFX = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_instr,
  output logic [DW-1:0] out_imm,
  output logic [2:0]    out_fmt,
  output logic          out_ext,
  output logic          err_orphan
);

  localparam int unsigned PW  = 12;
  localparam int unsigned FW  = 9;
  localparam int unsigned AW  = MAX_PFX * PW;
  localparam int unsigned RW  = AW + FW;
  localparam int unsigned XW  = (RW > DW) ? RW : DW;
  localparam int unsigned IW  = $clog2(XW);
  localparam int unsigned CW  = 2;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  logic          out_valid_q,  out_valid_d;
  logic [15:0]   out_instr_q,  out_instr_d;
  logic [DW-1:0] out_imm_q,    out_imm_d;
  logic [2:0]    out_fmt_q,    out_fmt_d;
  logic          out_ext_q,    out_ext_d;
  logic          err_orphan_q, err_orphan_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic [AW-1:0] acc_q,        acc_d;

  logic [2:0]    fmt_c;
  logic [FW-1:0] fld_c;
  int unsigned   fw_c;
  logic          is_ext_c;
  logic          accept_c;
  logic [XW-1:0] raw_c;
  logic [DW-1:0] sext_c;
  int unsigned   len_c;
  logic          sign_c;

  // Opcode decode: format class, immediate field and its width.
  always_comb begin
    fmt_c    = FMT_R;
    fld_c    = '0;
    fw_c     = 0;
    is_ext_c = 1'b0;
    case (in_instr[3:0])
      4'h1, 4'h9: begin fmt_c = FMT_I; fld_c = FW'(in_instr[15:12]); fw_c = 4; end
      4'h2:       begin fmt_c = FMT_S; fld_c = FW'(in_instr[7:4]);   fw_c = 4; end
      4'h3, 4'hB: begin fmt_c = FMT_B; fld_c = FW'(in_instr[7:4]);   fw_c = 4; end
      4'h4, 4'hC: begin fmt_c = FMT_J; fld_c = in_instr[15:7];       fw_c = 9; end
      4'hF:       is_ext_c = 1'b1;
      default:    ;
    endcase
  end

  // Concatenate pending payloads with the field, then sign-extend from the
  // MSB of that variable-length value (truncation falls out when len >= DW).
  always_comb begin
    raw_c  = (XW'(acc_q) << fw_c) | XW'(fld_c);
    len_c  = 32'(cnt_q) * PW + fw_c;
    sign_c = 1'b0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (i + 1 == len_c) sign_c = raw_c[IW'(i)];
    end
    sext_c = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      sext_c[i] = (i < len_c) ? raw_c[IW'(i)] : sign_c;
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept_c = in_valid && in_ready;

  // Next-state: flush beats everything, then EXT absorb, then a new beat,
  // then a plain drain; otherwise (backpressure/idle) everything holds.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ext_d    = out_ext_q;
    err_orphan_d = 1'b0;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    if (flush) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
      acc_d       = '0;
    end else if (accept_c && is_ext_c) begin
      if (32'(cnt_q) < MAX_PFX) begin
        acc_d = (acc_q << PW) | AW'(in_instr[15:4]);
        cnt_d = cnt_q + CW'(1);
      end else begin
        // Chain overflow: restart the chain with this payload only.
        err_orphan_d = 1'b1;
        acc_d        = AW'(in_instr[15:4]);
        cnt_d        = CW'(1);
      end
      if (out_ready) out_valid_d = 1'b0;
    end else if (accept_c) begin
      out_valid_d  = 1'b1;
      out_instr_d  = in_instr;
      out_fmt_d    = fmt_c;
      out_imm_d    = (fmt_c == FMT_R) ? '0 : sext_c;
      out_ext_d    = (fmt_c != FMT_R) && (cnt_q != '0);
      err_orphan_d = (fmt_c == FMT_R) && (cnt_q != '0);
      cnt_d        = '0;
      acc_d        = '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_imm_q    <= '0;
      out_fmt_q    <= '0;
      out_ext_q    <= 1'b0;
      err_orphan_q <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ext_q    <= out_ext_d;
      err_orphan_q <= err_orphan_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_imm    = out_imm_q;
  assign out_fmt    = out_fmt_q;
  assign out_ext    = out_ext_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (DW=16/MAX_PFX=1 and DW=32/MAX_PFX=2)
// share one input stream; an arithmetic reference model predicts each lane.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_ext, a_err;
  logic [15:0] a_out_instr, a_out_imm;
  logic [2:0]  a_out_fmt;
  logic        b_in_ready, b_out_valid, b_out_ext, b_err;
  logic [15:0] b_out_instr;
  logic [31:0] b_out_imm;
  logic [2:0]  b_out_fmt;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DW(16), .MAX_PFX(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_ext(a_out_ext),
    .err_orphan(a_err)
  );

  imm_gen_pipe #(.DW(32), .MAX_PFX(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_ext(b_out_ext),
    .err_orphan(b_err)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending prefixes kept as a base-4096 number plus a count.
  bit          started = 1'b0;
  bit          m_valid [2];
  logic [15:0] m_instr [2];
  longint      m_imm   [2];
  int          m_fmt   [2];
  bit          m_ext   [2];
  bit          m_err   [2];
  int          m_cnt   [2];
  longint      m_acc   [2];

  task automatic model_step(input int k);
    int dw, mp, fmt, w, len;
    longint f, raw, s;
    bit acc_ok;
    dw = (k == 0) ? 16 : 32;
    mp = (k == 0) ? 1 : 2;
    if (!rst_n) begin
      m_valid[k] = 0; m_instr[k] = '0; m_imm[k] = 0; m_fmt[k] = 0;
      m_ext[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_acc[k] = 0;
      return;
    end
    acc_ok   = in_valid && (!m_valid[k] || out_ready);
    m_err[k] = 0;
    fmt = 0; f = 0; w = 0;
    case (in_instr[3:0])
      4'h1, 4'h9: begin fmt = 1; f = longint'(in_instr[15:12]); w = 4; end
      4'h2:       begin fmt = 2; f = longint'(in_instr[7:4]);   w = 4; end
      4'h3, 4'hB: begin fmt = 3; f = longint'(in_instr[7:4]);   w = 4; end
      4'h4, 4'hC: begin fmt = 4; f = longint'(in_instr[15:7]);  w = 9; end
      default:    ;
    endcase
    if (flush) begin
      m_valid[k] = 0; m_cnt[k] = 0; m_acc[k] = 0;
    end else if (acc_ok && in_instr[3:0] == 4'hF) begin
      if (m_cnt[k] < mp) begin
        m_acc[k] = m_acc[k] * 4096 + longint'(in_instr[15:4]);
        m_cnt[k]++;
      end else begin
        m_err[k] = 1;
        m_acc[k] = longint'(in_instr[15:4]);
        m_cnt[k] = 1;
      end
      if (out_ready) m_valid[k] = 0;
    end else if (acc_ok) begin
      m_valid[k] = 1;
      m_instr[k] = in_instr;
      m_fmt[k]   = fmt;
      if (fmt == 0) begin
        m_imm[k] = 0;
        m_ext[k] = 0;
        m_err[k] = (m_cnt[k] > 0);
      end else begin
        len = m_cnt[k] * 12 + w;
        raw = m_acc[k] * (longint'(1) << w) + f;
        s   = (raw >= (longint'(1) << (len - 1))) ? raw - (longint'(1) << len) : raw;
        m_imm[k] = s & ((longint'(1) << dw) - 1);
        m_ext[k] = (m_cnt[k] > 0);
      end
      m_cnt[k] = 0;
      m_acc[k] = 0;
    end else if (out_ready) begin
      m_valid[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) started = 1'b1;
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic cmp_lane(input int k, input logic rdy, input logic vld,
                          input logic [15:0] ins, input longint imm,
                          input logic [2:0] fmt, input logic ext, input logic err);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".in_ready"}, longint'(rdy), longint'(!m_valid[k] || out_ready));
    chk({p, ".out_valid"}, longint'(vld), longint'(m_valid[k]));
    chk({p, ".err_orphan"}, longint'(err), longint'(m_err[k]));
    if (m_valid[k]) begin
      chk({p, ".out_instr"}, longint'(ins), longint'(m_instr[k]));
      chk({p, ".out_imm"}, imm, m_imm[k]);
      chk({p, ".out_fmt"}, longint'(fmt), longint'(m_fmt[k]));
      chk({p, ".out_ext"}, longint'(ext), longint'(m_ext[k]));
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_lane(0, a_in_ready, a_out_valid, a_out_instr, longint'(a_out_imm),
               a_out_fmt, a_out_ext, a_err);
      cmp_lane(1, b_in_ready, b_out_valid, b_out_instr, longint'(b_out_imm),
               b_out_fmt, b_out_ext, b_err);
    end
  end

  task automatic step(input bit v, input logic [15:0] ins, input bit fl,
                      input bit ordy, input bit rn);
    in_valid  = v;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    rst_n     = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic lit_a(input string n, input longint imm, input int fmt, input bit ext);
    chk({n, ".valid"}, longint'(a_out_valid), 1);
    chk({n, ".imm"}, longint'(a_out_imm), imm);
    chk({n, ".fmt"}, longint'(a_out_fmt), longint'(fmt));
    chk({n, ".ext"}, longint'(a_out_ext), longint'(ext));
  endtask

  initial begin
    logic [15:0] r;
    // Reset: every output zero, ready high.
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);
    chk("rst.valid", longint'(a_out_valid), 0);
    chk("rst.instr", longint'(a_out_instr), 0);
    chk("rst.imm", longint'(b_out_imm), 0);
    chk("rst.fmt", longint'(a_out_fmt), 0);
    chk("rst.ext", longint'(b_out_ext), 0);
    chk("rst.err", longint'(a_err), 0);
    chk("rst.in_ready", longint'(a_in_ready), 1);

    // I-type and J-type sign handling, back-to-back.
    step(1, 16'h3111, 0, 1, 1); lit_a("i_pos", 64'h0003, 1, 0);
    step(1, 16'hD111, 0, 1, 1); lit_a("i_neg", 64'hFFFD, 1, 0);
    chk("i_neg32", longint'(b_out_imm), 64'hFFFF_FFFD);
    step(1, 16'h7F84, 0, 1, 1); lit_a("j_max", 64'h00FF, 4, 0);
    step(1, 16'h800C, 0, 1, 1); lit_a("j_min", 64'hFF00, 4, 0);

    // Single prefix: EXT produces no beat.
    step(1, 16'h123F, 0, 1, 1);
    chk("ext.nobeat", longint'(a_out_valid), 0);
    step(1, 16'h5111, 0, 1, 1); lit_a("pfx1", 64'h1235, 1, 1);
    step(0, 16'h0, 0, 1, 1);
    chk("pfx1.drain", longint'(a_out_valid), 0);

    // Backpressure then back-to-back drain.
    step(1, 16'h3111, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h2222, 0, 0, 1);
      chk("bp.in_ready", longint'(a_in_ready), 0);
      lit_a("bp.hold", 64'h0003, 1, 0);
      chk("bp.instr", longint'(a_out_instr), 64'h3111);
    end
    step(1, 16'h2222, 0, 1, 1); lit_a("bp.s", 64'h0002, 2, 0);
    step(1, 16'h1111, 0, 1, 1); lit_a("bp.i", 64'h0001, 1, 0);
    step(0, 16'h0, 0, 1, 1);

    // Orphan prefix.
    step(1, 16'h123F, 0, 1, 1);
    step(1, 16'h0020, 0, 1, 1);
    lit_a("orphan", 0, 0, 0);
    chk("orphan.err", longint'(a_err), 1);
    step(0, 16'h0, 0, 1, 1);
    chk("orphan.pulse", longint'(a_err), 0);

    // Flush discards the pending prefix.
    step(1, 16'h123F, 0, 1, 1);
    step(0, 16'h0, 1, 1, 1);
    chk("flush.valid", longint'(a_out_valid), 0);
    step(1, 16'h3111, 0, 1, 1); lit_a("flush.after", 64'h0003, 1, 0);

    // Reset mid-prefix.
    step(1, 16'h123F, 0, 1, 1);
    step(0, 16'h0, 0, 1, 0);
    chk("rst2.valid", longint'(a_out_valid), 0);
    chk("rst2.imm", longint'(a_out_imm), 0);
    chk("rst2.instr", longint'(a_out_instr), 0);
    step(1, 16'h3111, 0, 1, 1); lit_a("rst2.after", 64'h0003, 1, 0);

    // Two chained prefixes on the 32-bit lane.
    step(1, 16'hFFFF, 0, 1, 1);
    step(1, 16'hFFFF, 0, 1, 1);
    chk("pfx2.b_err", longint'(b_err), 0);
    chk("pfx2.a_err", longint'(a_err), 1);
    step(1, 16'hE111, 0, 1, 1);
    chk("pfx2.imm", longint'(b_out_imm), 64'hFFFF_FFFE);
    chk("pfx2.ext", longint'(b_out_ext), 1);
    lit_a("pfx2.a", 64'hFFFE, 1, 1);

    // Third prefix overflows the 32-bit lane.
    step(1, 16'hFFFF, 0, 1, 1);
    step(1, 16'hFFFF, 0, 1, 1);
    step(1, 16'hFFFF, 0, 1, 1);
    chk("pfx3.err", longint'(b_err), 1);
    step(1, 16'hE111, 0, 1, 1);
    chk("pfx3.imm", longint'(b_out_imm), 64'hFFFF_FFFE);

    // Randomized traffic, checked by the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 2) == 0) r[3:0] = 4'hF;
      step(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
    end
    step(0, 16'h0, 0, 1, 1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
